seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment display; Basys 3 default is 4 digits.
- Holds a double-buffered hex value plus decimal points and scans one digit per refresh slot.
- Drives shared cathodes and per-digit anodes, both active-low.
- Sits between any value producer (counters, debug registers) and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal minimum 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures hex_in/dp_in into the shadow buffer.
- hex_in  in  4*DIGITS  nibble k = digit k; digit 0 is rightmost, LSB nibble.
- dp_in  in  DIGITS  bit k = 1 lights the decimal point of digit k.
- blank_in  in  DIGITS  bit k = 1 forces digit k dark; sampled live, not buffered.
- an  out  DIGITS  anodes, active-low, one-hot-low while scanning.
- segment  out  8  cathodes, active-low; bit7 = DP, bits 6:0 = G,F,E,D,C,B,A.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
- pending  out  1  shadow holds data not yet shown.

Behaviour:
- Reset values (asynchronous):
  - an = all 1s; segment = 8'hFF.
  - frame_tick = 0; pending = 0.
  - slot counter = 0; digit index = 0.
  - Shadow and display registers = 0.
- Slot counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, the digit index increments, wrapping from DIGITS-1 to 0.
- Output timing:
  - an and segment are registered.
  - Both change on the same edge that moves the digit index, so no ghosting is introduced by skew.
  - First digit 0 drive occurs on the first clk edge after reset release.
- Anode drive:
  - an bit for the current index = 0; all other bits = 1.
  - If blank_in[index] = 1, all an bits = 1 and segment = 8'hFF for that slot.
- Segment decode (G..A, 0 = lit):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Decimal point: segment[7] = ~display_dp[index].
- Double buffering:
  - load: shadow <= {hex_in, dp_in}; pending <= 1.
  - Frame boundary (cycle where counter = REFRESH_DIV-1 and index = DIGITS-1): if pending, display <= shadow and pending <= 0. Otherwise display is unchanged.
  - frame_tick asserts the cycle after that boundary, coincident with the digit 0 drive.
- Simultaneous load and frame boundary: hex_in/dp_in go to both shadow and display; pending = 0.
- Back-to-back loads: the last one before the boundary wins; earlier values are discarded.
- DIGITS = 1: the index stays 0. Every REFRESH_DIV cycles is a frame boundary, and frame_tick pulses each slot.
- Reset mid-frame: outputs blank immediately; the shadow contents are lost.

Optional Feature:
- Macro: SEVEN_SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k (k > 0) is blanked if display nibbles k..DIGITS-1 are all 0 and display_dp[k] = 0.
  - Digit 0 is never auto-blanked.
  - Blanking is OR'd with blank_in and evaluated from the display register, not the shadow.
- Undefined: all digits show their nibble, including leading zeros. No extra logic.

Test Plan (DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset release with display at 0 → an = 1110, segment = 8'hC0 on the first edge; an sequence 1110→1101→1011→0111 every 4 cycles. frame_tick pulses once every 16 cycles, coincident with an = 1110.
- load with hex_in = 16'h1A2F, dp_in = 4'b0100 mid-frame → pending = 1 until the boundary. Next frame shows:
  - digit 0 = 0x8E
  - digit 1 = 0xA4
  - digit 2 = 0x08 (A with DP lit)
  - digit 3 = 0xF9
- load coincident with the frame-boundary cycle, hex_in = 16'h0009 → pending stays 0; the next digit 0 shows 0x90.
- blank_in = 4'b0010 → during the digit 1 slot, an = 1111 and segment = 8'hFF; other slots unaffected.
- Assert reset during the digit 2 slot with pending = 1 → an = 1111, segment = 8'hFF, pending = 0 without waiting for a clk edge.
- With SEVEN_SEG_SCAN_LZ_BLANK_EN and value 16'h0050 → digits 3 and 2 dark, digits 1 and 0 show 0x92 and 0xC0. Same stimulus with the macro undefined → digits 3 and 2 show 0xC0.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a common-anode seven-segment display with a double-buffered value.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_SCAN_LZ_BLANK_EN.
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          segment,
  output logic                frame_tick,
  output logic                pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_hex;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_hex;
  logic [DIGITS-1:0]   disp_dp;

  logic                slot_end;
  logic                boundary;
  logic [IDX_W-1:0]    idx_nxt;
  logic [4*DIGITS-1:0] disp_hex_nxt;
  logic [DIGITS-1:0]   disp_dp_nxt;
  logic [DIGITS-1:0]   dark;
  logic [DIGITS-1:0]   onehot;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an_nxt;
  logic [7:0]          seg_nxt;

  // Active-low G..A pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b0000011;
      4'hC:    decode = 7'b1000110;
      4'hD:    decode = 7'b0100001;
      4'hE:    decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
  // Digit k>0 goes dark while it and every digit above it are zero, unless its DP is lit.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] hex,
                                                input logic [DIGITS-1:0]   dp);
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      run        = run & (hex[k*4 +: 4] == 4'h0);
      lz_mask[k] = run & ~dp[k];
    end
  endfunction
`endif

  assign slot_end = (cnt == CNT_MAX);
  assign boundary = slot_end && (idx == IDX_MAX);

  // Outputs are computed from next-state index and display so they move on the same edge.
  always_comb begin
    idx_nxt = idx;
    if (slot_end) idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;

    disp_hex_nxt = disp_hex;
    disp_dp_nxt  = disp_dp;
    if (boundary) begin
      if (load) begin
        disp_hex_nxt = hex_in;
        disp_dp_nxt  = dp_in;
      end else if (pending) begin
        disp_hex_nxt = shadow_hex;
        disp_dp_nxt  = shadow_dp;
      end
    end

`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    dark = blank_in | lz_mask(disp_hex_nxt, disp_dp_nxt);
`else
    dark = blank_in;
`endif

    onehot          = '0;
    onehot[idx_nxt] = 1'b1;
    nibble          = disp_hex_nxt[{idx_nxt, 2'b00} +: 4];
    if (dark[idx_nxt]) begin
      an_nxt  = '1;
      seg_nxt = 8'hFF;
    end else begin
      an_nxt  = ~onehot;
      seg_nxt = {~disp_dp_nxt[idx_nxt], decode(nibble)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_hex <= '0;
      shadow_dp  <= '0;
      disp_hex   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= '1;
      segment    <= 8'hFF;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= idx_nxt;
      if (load) begin
        shadow_hex <= hex_in;
        shadow_dp  <= dp_in;
      end
      disp_hex   <= disp_hex_nxt;
      disp_dp    <= disp_dp_nxt;
      // A load on the boundary cycle goes straight to the display, so nothing is left pending.
      pending    <= boundary ? 1'b0 : (load ? 1'b1 : pending);
      frame_tick <= boundary;
      an         <= an_nxt;
      segment    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4) plus a DIGITS=1 instance.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_tick;
  logic        pending;

  logic        load1 = 1'b0;
  logic [3:0]  hex1 = '0;
  logic [0:0]  dp1 = '0;
  logic [0:0]  blank1 = '0;
  logic [0:0]  an1;
  logic [7:0]  segment1;
  logic        frame_tick1;
  logic        pending1;

  int tests = 0;
  int fails = 0;

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .an(an), .segment(segment), .frame_tick(frame_tick),
    .pending(pending)
  );

  seven_seg_scan #(.DIGITS(1), .REFRESH_DIV(3)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .hex_in(hex1), .dp_in(dp1),
    .blank_in(blank1), .an(an1), .segment(segment1), .frame_tick(frame_tick1),
    .pending(pending1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  dark;
    logic [7:0]  seg [4];
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_frame_tick(input string name, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s: got no frame_tick expected one within %0d cycles", name, budget);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [15:0] hex, input logic [3:0] dp,
                              input logic [3:0] blank, input logic [3:0] dark,
                              input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
    vec_t v;
    v.name = name; v.hex = hex; v.dp = dp; v.blank = blank; v.dark = dark;
    v.seg[0] = s0; v.seg[1] = s1; v.seg[2] = s2; v.seg[3] = s3;
    return v;
  endfunction

  initial begin
    logic [3:0] exp_an;
    logic [7:0] exp_seg;

    vecs[0] = mk("v1A2F",   16'h1A2F, 4'b0100, 4'b0000, 4'b0000, 8'hF9, 8'h08, 8'hA4, 8'h8E);
    vecs[1] = mk("v0009",   16'h0009, 4'b0000, 4'b0000, 4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'h90);
    vecs[2] = mk("v0050",   16'h0050, 4'b0000, 4'b0000, 4'b0000, 8'hC0, 8'hC0, 8'h92, 8'hC0);
    vecs[3] = mk("blank1",  16'h3210, 4'b0000, 4'b0010, 4'b0010, 8'hB0, 8'hA4, 8'hF9, 8'hC0);
    vecs[4] = mk("vBCDEdp", 16'hBCDE, 4'b1111, 4'b0000, 4'b0000, 8'h03, 8'h46, 8'h21, 8'h06);
    vecs[5] = mk("v4567",   16'h4567, 4'b0001, 4'b0000, 4'b0000, 8'h99, 8'h92, 8'h82, 8'h78);
    vecs[6] = mk("lzdp",    16'h0001, 4'b0100, 4'b0000, 4'b0000, 8'hC0, 8'h40, 8'hC0, 8'hF9);
    vecs[7] = mk("v8000",   16'h8000, 4'b0000, 4'b0000, 4'b0000, 8'h80, 8'hC0, 8'hC0, 8'hC0);
`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
    vecs[1].dark = 4'b1110;
    vecs[2].dark = 4'b1100;
    vecs[6].dark = 4'b1010;
`endif

    // Asynchronous reset state before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {24'd0, segment}, 32'hFF);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);

    // Scan sequence and frame_tick period from reset release.
    @(negedge clk) reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((n / 4) % 4));
`ifdef SEVEN_SEG_SCAN_LZ_BLANK_EN
      if (((n / 4) % 4) != 0) exp_an = 4'hF;
`endif
      check($sformatf("scan_an_%0d", n), {28'd0, an}, {28'd0, exp_an});
      check($sformatf("scan_tick_%0d", n), {31'd0, frame_tick}, {31'd0, (n % 16) == 0});
      check($sformatf("d1_tick_%0d", n), {31'd0, frame_tick1}, {31'd0, (n % 3) == 0});
      check($sformatf("d1_an_%0d", n), {31'd0, an1}, 32'd0);
      if (n == 1) check("first_seg", {24'd0, segment}, 32'hC0);
    end

    // Table of values: load mid-frame, then check every digit slot of the next frame.
    foreach (vecs[i]) begin
      wait_frame_tick({vecs[i].name, "_sync"}, 40);
      hex_in = vecs[i].hex; dp_in = vecs[i].dp; blank_in = vecs[i].blank; load = 1'b1;
      @(negedge clk) load = 1'b0;
      check({vecs[i].name, "_pend1"}, {31'd0, pending}, 32'd1);
      wait_frame_tick({vecs[i].name, "_frame"}, 40);
      check({vecs[i].name, "_pend0"}, {31'd0, pending}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (4) @(negedge clk);
        exp_an  = vecs[i].dark[k] ? 4'hF : ~(4'b0001 << k);
        exp_seg = vecs[i].dark[k] ? 8'hFF : vecs[i].seg[k];
        check($sformatf("%s_d%0d_an", vecs[i].name, k), {28'd0, an}, {28'd0, exp_an});
        check($sformatf("%s_d%0d_seg", vecs[i].name, k), {24'd0, segment}, {24'd0, exp_seg});
      end
    end
    blank_in = '0;

    // Load on the frame-boundary cycle goes straight to the display.
    wait_frame_tick("coin_sync", 40);
    repeat (15) @(negedge clk);
    hex_in = 16'h0009; dp_in = 4'b0000; load = 1'b1;
    @(negedge clk) load = 1'b0;
    check("coin_pending", {31'd0, pending}, 32'd0);
    check("coin_tick", {31'd0, frame_tick}, 32'd1);
    check("coin_an", {28'd0, an}, 32'hE);
    check("coin_seg", {24'd0, segment}, 32'h90);

    // Back-to-back loads: the last one wins.
    wait_frame_tick("b2b_sync", 40);
    hex_in = 16'h1111; load = 1'b1;
    @(negedge clk) hex_in = 16'h2222;
    @(negedge clk) load = 1'b0;
    wait_frame_tick("b2b_frame", 40);
    check("b2b_d0_seg", {24'd0, segment}, 32'hA4);
    repeat (4) @(negedge clk);
    check("b2b_d1_seg", {24'd0, segment}, 32'hA4);

    // Reset during the digit 2 slot with a pending load.
    wait_frame_tick("arst_sync", 40);
    hex_in = 16'h0000; load = 1'b1;
    @(negedge clk) load = 1'b0;
    hex_in = 16'h7777;
    load = 1'b1;
    @(negedge clk) load = 1'b0;
    repeat (7) @(negedge clk);
    check("arst_pre_an", {28'd0, an}, 32'hB);
    check("arst_pre_pending", {31'd0, pending}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_an", {28'd0, an}, 32'hF);
    check("arst_seg", {24'd0, segment}, 32'hFF);
    check("arst_pending", {31'd0, pending}, 32'd0);
    check("arst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("arst_rel_an", {28'd0, an}, 32'hE);
    check("arst_rel_seg", {24'd0, segment}, 32'hC0);
    wait_frame_tick("arst_frame", 40);
    check("arst_lost_seg", {24'd0, segment}, 32'hC0);
    check("arst_lost_pending", {31'd0, pending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
